// File: rtl/onehot_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// onehot_rr_arbiter_pkg
// Shared constants for the round-robin arbiter slice: default requester count,
// default beat width and a constant clog2 used to size the binary grant index.
// ----------------------------------------------------------------------------
package onehot_rr_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

    // Ceiling log2 for elaboration-time sizing (n >= 2 in practice).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// onehot_rr_arbiter_if
// Bundles the requester side (i_req/i_data/i_last), the downstream ready and
// the arbiter outputs into one interface.
//   master : producers/consumer side, drives i_*, observes o_*
//   slave  : the arbiter, observes i_*, drives o_*
// Signals:
//   i_req    [NUM_REQ]        per-requester request/valid
//   i_data   [NUM_REQ*WIDTH]  packed beats, requester k at [k*WIDTH +: WIDTH]
//   i_last   [NUM_REQ]        per-requester end-of-burst flag
//   i_ready  [1]              downstream accepts beat
//   o_gnt    [NUM_REQ]        registered one-hot grant
//   o_gnt_idx[IDX_W]          binary index of o_gnt
//   o_valid, o_data[WIDTH], o_last, o_busy
// ----------------------------------------------------------------------------
interface onehot_rr_arbiter_if
    import onehot_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IDX_W   = clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]       i_req;
    logic [NUM_REQ*WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0]       i_last;
    logic                     i_ready;
    logic [NUM_REQ-1:0]       o_gnt;
    logic [IDX_W-1:0]         o_gnt_idx;
    logic                     o_valid;
    logic [WIDTH-1:0]         o_data;
    logic                     o_last;
    logic                     o_busy;

    modport master (
        output i_req, i_data, i_last, i_ready,
        input  o_gnt, o_gnt_idx, o_valid, o_data, o_last, o_busy
    );

    modport slave (
        input  i_req, i_data, i_last, i_ready,
        output o_gnt, o_gnt_idx, o_valid, o_data, o_last, o_busy
    );

endinterface

// File: rtl/onehot_rr_arbiter_mux.sv
// ----------------------------------------------------------------------------
// OnehotMultiplexer
// AND-OR multiplexer steered by a one-hot select. An all-zero select yields
// an all-zero output, which the arbiter relies on for its idle outputs.
// Ports:
//   sel_i  [SEL_WIDTH]        one-hot select
//   data_i [SEL_WIDTH*WIDTH]  packed inputs, lane k at [k*WIDTH +: WIDTH]
//   data_o [WIDTH]            selected lane
// ----------------------------------------------------------------------------
module OnehotMultiplexer #(
    parameter int SEL_WIDTH = 4,
    parameter int WIDTH     = 8
) (
    input  logic [SEL_WIDTH-1:0]       sel_i,
    input  logic [SEL_WIDTH*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]           data_o
);

    always_comb begin
        data_o = '0;
        for (int k = 0; k < SEL_WIDTH; k++) begin
            data_o = data_o | (data_i[k*WIDTH +: WIDTH] & {WIDTH{sel_i[k]}});
        end
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// ----------------------------------------------------------------------------
// onehot_rr_arbiter
// Round-robin arbiter sharing one ready/valid channel among NUM_REQ
// requesters. The grant is registered one-hot and locked until a beat with
// end-of-burst is accepted; on release the next requester is granted on the
// same edge, so back-to-back bursts have no idle cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   arb  onehot_rr_arbiter_if.slave (requests, data, last, ready in;
//        grant, grant index, valid, data, last, busy out)
// ----------------------------------------------------------------------------
module onehot_rr_arbiter
    import onehot_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    onehot_rr_arbiter_if.slave      arb
);

    localparam int IDX_W = clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0] req_mask;
    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   cand_idx;
    logic [IDX_W-1:0]   gnt_idx;
    logic               xfer;
    logic               valid;
    logic               last;
    logic [NUM_REQ-1:0] last_q_req;

    // First asserted request at or after ptr, wrapping past NUM_REQ-1.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [NUM_REQ-1:0] pick;
        logic               found;
        logic [IDX_W-1:0]   idx;
        int                 k;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            idx = IDX_W'(k);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    // On release the releasing requester is masked out so it cannot be
    // re-granted on the same edge.
    always_comb begin
        req_mask = arb.i_req;
        if (state_q == LOCK) begin
            req_mask = arb.i_req & ~gnt_q;
        end
        cand = rr_pick(req_mask, ptr_q);
    end

    // One-hot to binary for both the candidate and the held grant.
    always_comb begin
        cand_idx = '0;
        gnt_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand[i]) begin
                cand_idx = cand_idx | IDX_W'(i);
            end
            if (gnt_q[i]) begin
                gnt_idx = gnt_idx | IDX_W'(i);
            end
        end
    end

    assign valid = |(gnt_q & arb.i_req);
    assign xfer  = valid & arb.i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = LOCK;
                    gnt_d   = cand;
                    ptr_d   = (cand_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cand_idx + 1'b1;
                end
            end
            LOCK: begin
                if (xfer && last) begin
                    gnt_d = cand;
                    if (|cand) begin
                        state_d = LOCK;
                        ptr_d   = (cand_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cand_idx + 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign last_q_req = arb.i_last & arb.i_req;

    OnehotMultiplexer #(
        .SEL_WIDTH (NUM_REQ),
        .WIDTH     (WIDTH)
    ) u_data_mux (
        .sel_i  (gnt_q),
        .data_i (arb.i_data),
        .data_o (arb.o_data)
    );

    OnehotMultiplexer #(
        .SEL_WIDTH (NUM_REQ),
        .WIDTH     (1)
    ) u_last_mux (
        .sel_i  (gnt_q),
        .data_i (last_q_req),
        .data_o (last)
    );

    assign arb.o_gnt     = gnt_q;
    assign arb.o_gnt_idx = gnt_idx;
    assign arb.o_valid   = valid;
    assign arb.o_last    = last;
    assign arb.o_busy    = (state_q == LOCK);

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_onehot_rr_arbiter
// Directed bench for onehot_rr_arbiter (NUM_REQ=4, WIDTH=8). Inputs change
// 1 ns after a rising edge; outputs are sampled 1 ns after inputs settle.
// ----------------------------------------------------------------------------
module tb_onehot_rr_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    onehot_rr_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

    onehot_rr_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant-related outputs in one go.
    task automatic chk_gnt(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic busy);
        #1;
        chk({tag, ".gnt"},  32'(bus.o_gnt),     32'(g));
        chk({tag, ".idx"},  32'(bus.o_gnt_idx), 32'(idx));
        chk({tag, ".busy"}, 32'(bus.o_busy),    32'(busy));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst          = 1'b1;
        bus.i_req    = '0;
        bus.i_data   = '0;
        bus.i_last   = '0;
        bus.i_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_gnt("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset.valid", 32'(bus.o_valid), 32'd0);
        chk("reset.data",  32'(bus.o_data),  32'd0);
        chk("reset.last",  32'(bus.o_last),  32'd0);

        // All requesting, single beats: grant walks 0,1,2,3,0.
        bus.i_req   = 4'b1111;
        bus.i_last  = 4'b1111;
        bus.i_data  = 32'h44332211;
        bus.i_ready = 1'b1;
        #1;
        chk("rr.idle_valid", 32'(bus.o_valid), 32'd0);
        tick(); chk_gnt("rr0", 4'b0001, 2'd0, 1'b1);
        chk("rr0.data",  32'(bus.o_data),  32'h11);
        chk("rr0.valid", 32'(bus.o_valid), 32'd1);
        chk("rr0.last",  32'(bus.o_last),  32'd1);
        tick(); chk_gnt("rr1", 4'b0010, 2'd1, 1'b1);
        chk("rr1.data", 32'(bus.o_data), 32'h22);
        tick(); chk_gnt("rr2", 4'b0100, 2'd2, 1'b1);
        chk("rr2.data", 32'(bus.o_data), 32'h33);
        tick(); chk_gnt("rr3", 4'b1000, 2'd3, 1'b1);
        chk("rr3.data", 32'(bus.o_data), 32'h44);
        tick(); chk_gnt("rr4", 4'b0001, 2'd0, 1'b1);
        bus.i_req = 4'b0001;
        tick(); chk_gnt("rr.idle", 4'b0000, 2'd0, 1'b0);
        chk("rr.idle_data", 32'(bus.o_data), 32'd0);
        bus.i_req = 4'b0000;
        tick(); chk_gnt("rr.idle2", 4'b0000, 2'd0, 1'b0);

        // Requester 2 burst of three with requester 0 waiting (ptr=1).
        bus.i_req  = 4'b0101;
        bus.i_last = 4'b0001;
        bus.i_data = 32'h00A10055;
        tick(); chk_gnt("b2.1", 4'b0100, 2'd2, 1'b1);
        chk("b2.1.data", 32'(bus.o_data), 32'hA1);
        chk("b2.1.last", 32'(bus.o_last), 32'd0);
        bus.i_data = 32'h00A20055;
        tick(); chk_gnt("b2.2", 4'b0100, 2'd2, 1'b1);
        chk("b2.2.data", 32'(bus.o_data), 32'hA2);
        bus.i_data = 32'h00A30055;
        bus.i_last = 4'b0101;
        #1;
        chk("b2.3.data", 32'(bus.o_data), 32'hA3);
        chk("b2.3.last", 32'(bus.o_last), 32'd1);
        tick(); chk_gnt("b2.next", 4'b0001, 2'd0, 1'b1);
        chk("b2.next.data", 32'(bus.o_data), 32'h55);

        // Requester 1 burst with a 4-cycle stall; requester 3 must wait.
        bus.i_req  = 4'b1011;
        bus.i_last = 4'b0001;
        bus.i_data = 32'hD300B155;
        tick(); chk_gnt("b1.start", 4'b0010, 2'd1, 1'b1);
        chk("b1.start.data", 32'(bus.o_data), 32'hB1);
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk_gnt("b1.stall", 4'b0010, 2'd1, 1'b1);
            chk("b1.stall.valid", 32'(bus.o_valid), 32'd1);
            chk("b1.stall.data",  32'(bus.o_data),  32'hB1);
        end
        bus.i_ready = 1'b1;
        tick(); chk_gnt("b1.beat2", 4'b0010, 2'd1, 1'b1);
        bus.i_data = 32'hD300B255;
        #1;
        chk("b1.beat2.data", 32'(bus.o_data), 32'hB2);

        // Requester 1 drops its request for two cycles mid-burst.
        bus.i_req = 4'b1000;
        #1;
        chk("b1.drop.valid", 32'(bus.o_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(); chk_gnt("b1.drop", 4'b0010, 2'd1, 1'b1);
            chk("b1.drop.valid2", 32'(bus.o_valid), 32'd0);
        end
        bus.i_req  = 4'b1010;
        bus.i_last = 4'b0010;
        bus.i_data = 32'hD300B355;
        #1;
        chk("b1.end.valid", 32'(bus.o_valid), 32'd1);
        chk("b1.end.last",  32'(bus.o_last),  32'd1);
        chk("b1.end.data",  32'(bus.o_data),  32'hB3);
        tick(); chk_gnt("b3.grant", 4'b1000, 2'd3, 1'b1);
        chk("b3.grant.data", 32'(bus.o_data), 32'hD3);

        // Only requester 3, single beats: grant alternates with idle.
        bus.i_req  = 4'b1000;
        bus.i_last = 4'b1000;
        tick(); chk_gnt("solo.idle1", 4'b0000, 2'd0, 1'b0);
        tick(); chk_gnt("solo.gnt",   4'b1000, 2'd3, 1'b1);
        tick(); chk_gnt("solo.idle2", 4'b0000, 2'd0, 1'b0);

        // Pointer wrapped to 0: requester 1 wins over 2.
        bus.i_req  = 4'b0110;
        bus.i_last = 4'b0000;
        tick(); chk_gnt("wrap", 4'b0010, 2'd1, 1'b1);
        bus.i_last = 4'b0010;
        tick(); chk_gnt("pre_rst", 4'b0100, 2'd2, 1'b1);
        bus.i_last = 4'b0000;

        // Reset mid-burst drops the grant and the pointer.
        rst = 1'b1;
        tick(); chk_gnt("rst.lock", 4'b0000, 2'd0, 1'b0);
        chk("rst.valid", 32'(bus.o_valid), 32'd0);
        chk("rst.data",  32'(bus.o_data),  32'd0);
        rst = 1'b0;
        bus.i_req = 4'b1010;
        tick(); chk_gnt("post_rst", 4'b0010, 2'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin arbiter that shares one downstream channel among NUM_REQ requesters, each presenting a WIDTH-bit data beat plus an end-of-burst flag. The block holds a registered one-hot grant, locks it for the duration of a burst, and steers the granted requester's data to the output through the team's one-hot multiplexer. It sits between multiple producers and a single ready/valid consumer.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- WIDTH, 8, data beat width
- IDX_W, clog2(NUM_REQ), width of binary grant index
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- i_req  in  NUM_REQ  per-requester valid/request
- i_data  in  NUM_REQ*WIDTH  packed beats; requester k occupies bits [k*WIDTH +: WIDTH]
- i_last  in  NUM_REQ  per-requester end-of-burst flag, qualified by i_req
- i_ready  in  1  downstream accepts beat
- o_gnt  out  NUM_REQ  registered one-hot grant (all-zero when idle)
- o_gnt_idx  out  IDX_W  binary index of o_gnt; 0 when idle
- o_valid  out  1  |(o_gnt & i_req)
- o_data  out  WIDTH  granted requester's beat; 0 when idle
- o_last  out  1  |(o_gnt & i_last & i_req)
- o_busy  out  1  grant held (state LOCK)

## Operation
- States: IDLE (o_gnt=0), LOCK (o_gnt one-hot, held).
- Rotating priority pointer ptr (IDX_W bits): search starts at ptr, wraps from NUM_REQ-1 to 0; first asserted i_req wins.
- IDLE: if any i_req → LOCK with winner granted, ptr ← winner+1 (mod NUM_REQ). Else stay IDLE.
- LOCK: transfer = o_valid & i_ready. Grant held until a transfer with o_last=1.
- Release (transfer & o_last): re-arbitrate same edge over i_req excluding the releasing requester; if a winner exists → LOCK with new grant (no dead cycle), else → IDLE. If only the releasing requester requests, it is not re-granted that edge; it reaches IDLE and is re-granted next cycle.
- Granted requester deasserting i_req mid-burst: grant held, o_valid=0, no transfer; no timeout.
- Non-granted requests are ignored in LOCK; no pre-emption.
- o_data / o_last combinational from o_gnt and inputs; zero when o_gnt=0.
- Reset: o_gnt=0, o_gnt_idx=0, o_busy=0, ptr=0, state IDLE; o_valid/o_data/o_last=0 as a consequence. Reset during a burst drops the grant immediately with no transfer completion.
- o_gnt never has more than one bit set (invariant).

## Timing
- Request-to-grant latency: 1 cycle from IDLE (req at edge N sampled → o_gnt valid after edge N).
- Back-to-back bursts: last beat accepted at edge N, next requester granted after edge N; zero idle cycles.
- Single-beat burst (i_last with first beat): grant lasts exactly the cycles until i_ready high.
- Data path: no register stage; i_data → o_data is combinational through the one-hot mux.
- i_ready may toggle freely; o_valid does not depend on i_ready.

## Structure
- Shared constants include: default NUM_REQ, WIDTH, and a clog2 function; state encoding localparams (IDLE=0, LOCK=1) local to the block.
- Data/last steering: instantiate existing OnehotMultiplexer (SEL_WIDTH=NUM_REQ, WIDTH=WIDTH) for o_data, and a second instance with WIDTH=1 for o_last.
- Rotating-priority search as a local function; one-hot-to-binary encoder inline. No further sub-modules.

## Test plan
- Reset then i_req=4'b1111, all single-beat, i_ready=1 → grants 0001,0010,0100,1000,0001 on consecutive cycles, o_gnt_idx 0,1,2,3,0.
- Requester 2 burst of 3 beats (data 0xA1,0xA2,0xA3, i_last on third), requester 0 requesting → o_gnt=0100 for 3 transfers, o_data matches, then 0001 on the next cycle with no gap.
- i_ready low for 4 cycles mid-burst of requester 1 → o_gnt held at 0010, o_valid=1, o_data stable; requester 3 request ignored until release.
- Requester 1 drops i_req mid-burst for 2 cycles → o_valid=0, grant held, burst resumes and completes on i_last.
- Only requester 3 requesting, repeated single beats → grant 1000, IDLE one cycle, re-grant 1000 (alternating); pointer wraps to 0.
- Assert rst during LOCK → next cycle o_gnt=0, o_busy=0, ptr=0; with i_req=4'b1010 first grant after reset is 0010.
